// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, pairs in-order responses with
// their PCs, presents the oldest filled entry to decode, and drains stale responses after a redirect.
module instr_fetch_queue #(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    DEPTH       = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [DATA_WIDTH-1:0]  i_PC,
   input  logic                   i_redirect,
   output logic                   o_imem_req_valid,
   output logic [DATA_WIDTH-1:0]  o_imem_addr,
   input  logic                   i_imem_req_ready,
   input  logic                   i_imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
   output logic                   o_instr_valid,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [DATA_WIDTH-1:0]  o_instr_pc,
   input  logic                   i_instr_ready,
   output logic                   o_rsp_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {RUN, DRAIN} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
   } entry_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] fetch_pc;
   entry_t                q [DEPTH];
   logic [DEPTH-1:0]      filled;
   logic [AW-1:0]         head, tail, fptr;
   logic [CW-1:0]         alloc_cnt, unfilled_cnt, drop_cnt, drop_nxt;
   logic                  req_acc, rsp_fill, rsp_drop, rsp_spur, pop;

   // Request eligibility uses only registered state, so a same-cycle pop never frees a slot.
   assign o_imem_req_valid = !i_rst && (state == RUN) && (alloc_cnt < CW'(DEPTH));
   assign o_imem_addr      = fetch_pc;
   assign req_acc          = o_imem_req_valid && i_imem_req_ready;

   assign o_instr_valid = (alloc_cnt != '0) && filled[head];
   assign o_instr       = q[head].instr;
   assign o_instr_pc    = q[head].pc;
   assign pop           = o_instr_valid && i_instr_ready;

   assign rsp_drop = i_imem_rsp_valid && (drop_cnt != '0);
   assign rsp_fill = i_imem_rsp_valid && (drop_cnt == '0) && (unfilled_cnt != '0);
   assign rsp_spur = i_imem_rsp_valid && (drop_cnt == '0) && (unfilled_cnt == '0);

   always_comb begin
      drop_nxt  = drop_cnt - CW'(rsp_drop);
      if (i_redirect && state == RUN)
         drop_nxt = unfilled_cnt + CW'(req_acc) - CW'(rsp_fill);
      state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= RUN;
         fetch_pc     <= RESET_PC;
         filled       <= '0;
         head         <= '0;
         tail         <= '0;
         fptr         <= '0;
         alloc_cnt    <= '0;
         unfilled_cnt <= '0;
         drop_cnt     <= '0;
         o_rsp_err    <= 1'b0;
      end else begin
         state    <= state_nxt;
         drop_cnt <= drop_nxt;
         if (rsp_spur)
            o_rsp_err <= 1'b1;
         if (i_redirect) begin
            // A concurrent pop has already been consumed; everything else is discarded.
            fetch_pc     <= i_PC & ~DATA_WIDTH'(3);
            filled       <= '0;
            head         <= '0;
            tail         <= '0;
            fptr         <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
         end else begin
            if (req_acc) begin
               fetch_pc     <= fetch_pc + DATA_WIDTH'(4);
               filled[tail] <= 1'b0;
               tail         <= tail + AW'(1);
            end
            if (rsp_fill) begin
               filled[fptr] <= 1'b1;
               fptr         <= fptr + AW'(1);
            end
            if (pop)
               head <= head + AW'(1);
            alloc_cnt    <= alloc_cnt + CW'(req_acc) - CW'(pop);
            unfilled_cnt <= unfilled_cnt + CW'(req_acc) - CW'(rsp_fill);
         end
      end
   end

   // Payload storage needs no reset; validity is carried by filled/alloc_cnt.
   always_ff @(posedge i_clk) begin
      if (!i_redirect && req_acc)
         q[tail].pc <= fetch_pc;
      if (!i_redirect && rsp_fill)
         q[fptr].instr <= i_imem_rsp_data;
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue with a queue-level reference model.
module tb_instr_fetch_queue;
   localparam int              DW     = 64;
   localparam int              IW     = 32;
   localparam int              DEPTH  = 4;
   localparam logic [DW-1:0]   RST_PC = '0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] i_PC = '0;
   logic          i_redirect = 1'b0;
   logic          o_imem_req_valid;
   logic [DW-1:0] o_imem_addr;
   logic          i_imem_req_ready = 1'b0;
   logic          i_imem_rsp_valid = 1'b0;
   logic [IW-1:0] i_imem_rsp_data = '0;
   logic          o_instr_valid;
   logic [IW-1:0] o_instr;
   logic [DW-1:0] o_instr_pc;
   logic          i_instr_ready = 1'b0;
   logic          o_rsp_err;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .i_clk(clk), .i_rst(rst), .i_PC(i_PC), .i_redirect(i_redirect),
      .o_imem_req_valid(o_imem_req_valid), .o_imem_addr(o_imem_addr),
      .i_imem_req_ready(i_imem_req_ready), .i_imem_rsp_valid(i_imem_rsp_valid),
      .i_imem_rsp_data(i_imem_rsp_data), .o_instr_valid(o_instr_valid), .o_instr(o_instr),
      .o_instr_pc(o_instr_pc), .i_instr_ready(i_instr_ready), .o_rsp_err(o_rsp_err));

   // Expected decode stream (live fetches not yet consumed) and memory's in-flight responses.
   typedef struct { logic [DW-1:0] pc; logic [IW-1:0] instr; bit filled; } exp_t;
   typedef struct { logic [IW-1:0] data; bit live; } mem_t;
   exp_t          expq[$];
   mem_t          pend[$];
   logic [DW-1:0] m_pc = RST_PC;
   bit            m_err = 1'b0;
   int            tests = 0, fails = 0;
   int            p_req, p_rsp, p_rdy, p_redir, p_spur;
   bit            rand_target;
   logic [DW-1:0] fixed_target;
   bit            ev;

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit draining();
      foreach (pend[i]) if (!pend[i].live) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: every cycle the head must match the oldest expected instruction.
   always @(negedge clk) begin
      if (!rst) begin
         ev = (expq.size() > 0) && expq[0].filled;
         check("instr_valid", DW'(o_instr_valid), DW'(ev));
         if (ev && i_instr_ready) begin
            check("instr_pc", o_instr_pc, expq[0].pc);
            check("instr", DW'(o_instr), DW'(expq[0].instr));
            void'(expq.pop_front());
         end
      end
   end

   task automatic step();
      bit            acc;
      logic [IW-1:0] d;
      mem_t          m;
      @(posedge clk); #1;
      check("req_valid", DW'(o_imem_req_valid), DW'(!draining() && expq.size() < DEPTH));
      if (o_imem_req_valid) check("imem_addr", o_imem_addr, m_pc);
      check("rsp_err", DW'(o_rsp_err), DW'(m_err));
      i_imem_req_ready = ($urandom_range(99) < p_req);
      if (pend.size() > 0) begin
         i_imem_rsp_valid = ($urandom_range(99) < p_rsp);
         i_imem_rsp_data  = pend[0].data;
      end else begin
         i_imem_rsp_valid = ($urandom_range(99) < p_spur);
         i_imem_rsp_data  = $urandom;
      end
      i_instr_ready = ($urandom_range(99) < p_rdy);
      i_redirect    = ($urandom_range(99) < p_redir);
      if (rand_target)
         case ($urandom_range(2))
            0: i_PC = {$urandom, $urandom};
            1: i_PC = DW'($urandom_range(255));
            default: i_PC = 64'hFFFF_FFFF_FFFF_FFF5;
         endcase
      else
         i_PC = fixed_target;
      @(negedge clk); #1;
      acc = o_imem_req_valid && i_imem_req_ready;
      if (i_imem_rsp_valid) begin
         if (pend.size() > 0) begin
            m = pend.pop_front();
            if (m.live)
               for (int i = 0; i < expq.size(); i++)
                  if (!expq[i].filled) begin expq[i].filled = 1'b1; break; end
         end else
            m_err = 1'b1;
      end
      if (acc) begin
         d = $urandom;
         pend.push_back('{data: d, live: !i_redirect});
         if (!i_redirect) expq.push_back('{pc: m_pc, instr: d, filled: 1'b0});
         m_pc = m_pc + 64'd4;
      end
      if (i_redirect) begin
         foreach (pend[i]) pend[i].live = 1'b0;
         expq.delete();
         m_pc = i_PC & ~64'd3;
      end
   endtask

   task automatic do_reset(bit mid);
      if (mid) begin @(posedge clk); #3; end
      rst = 1'b1;
      i_redirect = 1'b0; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_instr_ready = 1'b0;
      #1;
      check("rst_req_valid", DW'(o_imem_req_valid), '0);
      check("rst_instr_valid", DW'(o_instr_valid), '0);
      check("rst_rsp_err", DW'(o_rsp_err), '0);
      pend.delete(); expq.delete(); m_pc = RST_PC; m_err = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_req_valid", DW'(o_imem_req_valid), 64'd1);
      check("post_rst_addr", o_imem_addr, RST_PC);
   endtask

   task automatic phase(int n, int rq, int rs, int rd, int rdr, int sp);
      p_req = rq; p_rsp = rs; p_rdy = rd; p_redir = rdr; p_spur = sp;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rand_target = 1'b1; fixed_target = '0;
      do_reset(1'b0);
      phase(30, 100, 100, 100, 0, 0);   // streaming, one per cycle
      phase(20, 100, 100, 0, 0, 0);     // decode stalled: queue fills and holds
      phase(20, 100, 100, 100, 0, 0);
      rand_target = 1'b0; fixed_target = 64'h1003;
      phase(3, 100, 0, 0, 0, 0);        // build up unfilled requests
      phase(1, 100, 100, 0, 100, 0);    // redirect with accept + response in flight
      phase(15, 100, 100, 100, 0, 0);
      rand_target = 1'b1;
      phase(500, 60, 50, 60, 5, 0);     // random mix with redirects
      phase(12, 0, 100, 100, 0, 0);     // drain everything
      phase(1, 0, 0, 100, 0, 100);      // spurious response on empty queue
      phase(10, 100, 100, 100, 0, 0);   // error stays sticky
      rand_target = 1'b0; fixed_target = 64'hFFFF_FFFF_FFFF_FFF8;
      phase(1, 0, 100, 100, 100, 0);
      phase(10, 100, 100, 100, 0, 0);   // address wrap through zero
      rand_target = 1'b1;
      phase(6, 70, 50, 50, 0, 0);
      do_reset(1'b1);                   // mid-stream reset
      phase(200, 60, 50, 60, 5, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
